prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 320, is the instruction-memory depth in 32-bit words.
REQ-002 Parameter RGF_WORDS, default 32, is the register-file depth in 32-bit words.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  is an asynchronous, active-low reset.
REQ-005 start  input  1  is a one-cycle pulse that begins a load session; it is ignored unless the FSM is in IDLE.
REQ-006 s_valid  input  1  is the stream word-valid signal.
REQ-007 s_data  input  32  is the stream word.
REQ-008 s_last  input  1  marks the final word of a session.
REQ-009 s_ready  output  1  is the stream ready signal.
REQ-010 imem_we, imem_addr, imem_wdata  output  1/9/32  form the instruction-memory write port.
REQ-011 rgf_we, rgf_addr, rgf_wdata  output  1/5/32  form the register-file write port.
REQ-012 cpu_reset  output  1  holds the CPU in reset (active-high) while it is 1.
REQ-013 busy, done, err  output  1/1/1  report status.

Function
REQ-014 A beat is accepted when s_valid=1 and s_ready=1 on the same rising edge; s_data is held only by the handshake.
REQ-015 The FSM has six states: IDLE, HDR, IMEM, RGF, DONE, ERR.
REQ-016 In IDLE: s_ready=0, busy=0, cpu_reset holds its last value; start moves the FSM to HDR, sets cpu_reset=1 and clears err.
REQ-017 In HDR: s_ready=1.
- The accepted header gives N_I=s_data[8:0] and N_R=s_data[21:16].
REQ-018 Header validity:
- Header is illegal when N_I=0, N_I>IMEM_WORDS, N_R>RGF_WORDS, or s_last=1.
- Illegal header -> ERR; legal header -> IMEM, with both the word counter and the address cleared.
REQ-019 In IMEM: each accepted beat produces one registered write in the following cycle.
- imem_we=1, imem_addr=counter, imem_wdata=beat.
- The counter then increments.
REQ-020 On the N_I-th IMEM beat:
- N_R=0: s_last must be 1 -> DONE.
- N_R>0: s_last must be 0 -> RGF, counter cleared.
- Any other s_last value -> ERR.
REQ-021 In RGF: each accepted beat produces a registered write in the following cycle, rgf_we=1, rgf_addr=counter.
- Address 0 is written like any other address.
- The N_R-th beat must carry s_last=1 -> DONE; otherwise -> ERR.
REQ-022 s_last=1 on any IMEM or RGF beat other than the final expected beat -> ERR; that beat is not written.
REQ-023 In DONE (one cycle): done=1, cpu_reset=0, s_ready=0.
- DONE falls to IDLE next cycle.
- The final write strobe and done occur in the same cycle.
REQ-024 In ERR: err=1 (sticky until the next start), cpu_reset stays 1, s_ready=1, no writes.
- Beats are discarded until a beat with s_last=1 is accepted, then -> IDLE.
REQ-025 busy=1 in HDR, IMEM, RGF and ERR.
REQ-026 imem_we and rgf_we are never 1 in the same cycle, and each is 1 for exactly one cycle per accepted data beat.
REQ-027 s_valid low in any state stalls the FSM with no writes and no counter change (back-pressure-free wait).
REQ-028 start asserted outside IDLE has no effect.

Reset
REQ-029 reset_n=0 asynchronously forces:
- FSM=IDLE, counters=0, s_ready=0.
- imem_we=rgf_we=0, imem_addr=rgf_addr=0, imem_wdata=rgf_wdata=0.
- done=0, err=0, busy=0, cpu_reset=1.
REQ-030 Reset asserted mid-session abandons the session; words already written are not rolled back.
REQ-031 After reset_n deasserts, the first legal action is a start pulse; stream beats before start are not accepted.

Verification
REQ-032 start, header N_I=3 N_R=0, beats A,B,C with s_last on C -> imem writes addr 0..2 = A,B,C; done pulses with the C write; cpu_reset 1->0.
REQ-033 header N_I=2 N_R=32, 34 beats with s_last on the last beat -> 2 imem writes, then rgf writes addr 0..31; exactly one done.
REQ-034 header N_I=0 followed by 2 beats, s_last on the 2nd -> no writes; err=1; busy drops after the s_last beat; cpu_reset stays 1.
REQ-035 N_I=4 N_R=0 with s_last on beat 2 -> 1 imem write (beat 1 only); ERR; return to IDLE; the next start clears err.
REQ-036 Random s_valid gaps over an N_I=320 N_R=32 load -> write sequence identical to the gap-free run; IMEM addresses 0..319 with no skips.
REQ-037 reset_n pulsed low during the IMEM phase at beat 10 -> all outputs take reset values immediately; a subsequent full load completes normally.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a session into instruction memory and register file.
// The session is a header beat (N_I in [8:0], N_R in [21:16]), then N_I
// instruction words, then N_R register words. The CPU is held in reset from
// start until the session completes.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start                        begins a session (honoured in IDLE only)
//   s_valid, s_data, s_last      input stream; s_ready is the handshake
//   imem_we/imem_addr/imem_wdata instruction-memory write port
//   rgf_we/rgf_addr/rgf_wdata    register-file write port
//   cpu_reset                    active-high CPU reset
//   busy, done, err              status
module prog_loader #(
  parameter int unsigned IMEM_WORDS = 320,
  parameter int unsigned RGF_WORDS  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        imem_we,
  output logic [8:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        rgf_we,
  output logic [4:0]  rgf_addr,
  output logic [31:0] rgf_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned NR_W  = 6;
  localparam int unsigned RA_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_IMEM, S_RGF, S_DONE, S_ERR
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] n_i, n_i_next;
  logic [NR_W-1:0]  n_r, n_r_next;

  logic             imem_we_next, rgf_we_next;
  logic [8:0]       imem_addr_next;
  logic [RA_W-1:0]  rgf_addr_next;
  logic [31:0]      imem_wdata_next, rgf_wdata_next;
  logic             cpu_reset_next, err_next;
  logic             beat, last_i, last_r, hdr_bad;

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    n_i_next        = n_i;
    n_r_next        = n_r;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr;
    imem_wdata_next = imem_wdata;
    rgf_we_next     = 1'b0;
    rgf_addr_next   = rgf_addr;
    rgf_wdata_next  = rgf_wdata;
    cpu_reset_next  = cpu_reset;
    err_next        = err;

    beat    = s_valid && s_ready;
    last_i  = (cnt == (n_i - CNT_W'(1)));
    last_r  = (NR_W'(cnt) == (n_r - NR_W'(1)));
    hdr_bad = (s_data[8:0] == '0) ||
              (32'(s_data[8:0]) > IMEM_WORDS) ||
              (32'(s_data[21:16]) > RGF_WORDS) ||
              s_last;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next     = S_HDR;
          cpu_reset_next = 1'b1;
          err_next       = 1'b0;
        end
      end
      S_HDR: begin
        if (beat) begin
          n_i_next       = s_data[8:0];
          n_r_next       = s_data[21:16];
          cnt_next       = '0;
          imem_addr_next = '0;
          state_next     = hdr_bad ? S_ERR : S_IMEM;
        end
      end
      S_IMEM: begin
        if (beat) begin
          // s_last is legal only on the session's final word
          if (s_last && !(last_i && (n_r == '0))) begin
            state_next = S_ERR;
          end else begin
            imem_we_next    = 1'b1;
            imem_addr_next  = 9'(cnt);
            imem_wdata_next = s_data;
            cnt_next        = cnt + CNT_W'(1);
            if (last_i) begin
              if (n_r == '0) begin
                state_next = s_last ? S_DONE : S_ERR;
              end else begin
                state_next = S_RGF;
                cnt_next   = '0;
              end
            end
          end
        end
      end
      S_RGF: begin
        if (beat) begin
          if (s_last && !last_r) begin
            state_next = S_ERR;
          end else begin
            rgf_we_next    = 1'b1;
            rgf_addr_next  = RA_W'(cnt);
            rgf_wdata_next = s_data;
            cnt_next       = cnt + CNT_W'(1);
            if (last_r) state_next = s_last ? S_DONE : S_ERR;
          end
        end
      end
      S_DONE: state_next = S_IDLE;
      S_ERR: begin
        if (beat && s_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next == S_DONE) cpu_reset_next = 1'b0;
    if (state_next == S_ERR)  err_next       = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      n_i        <= '0;
      n_r        <= '0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      rgf_we     <= 1'b0;
      rgf_addr   <= '0;
      rgf_wdata  <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      n_i        <= n_i_next;
      n_r        <= n_r_next;
      s_ready    <= (state_next == S_HDR) || (state_next == S_IMEM) ||
                    (state_next == S_RGF) || (state_next == S_ERR);
      imem_we    <= imem_we_next;
      imem_addr  <= imem_addr_next;
      imem_wdata <= imem_wdata_next;
      rgf_we     <= rgf_we_next;
      rgf_addr   <= rgf_addr_next;
      rgf_wdata  <= rgf_wdata_next;
      cpu_reset  <= cpu_reset_next;
      busy       <= (state_next == S_HDR) || (state_next == S_IMEM) ||
                    (state_next == S_RGF) || (state_next == S_ERR);
      done       <= (state_next == S_DONE);
      err        <= err_next;
    end
  end

endmodule
